dense_bias_relu: RTL and testbench

Downstream stage of the dense-layer bias ROM. It receives one signed dot-product result per neuron, in neuron order, and drives the ROM read address so the matching bias arrives in step. It adds the bias with saturation, optionally applies ReLU, and presents the result on a registered valid/ready output with an end-of-vector marker. It sits between the dense MAC array and the next layer's input buffer.

---
 rtl/dense_pkg.sv | 24 ++
 rtl/dense_sat_relu.sv | 35 +++
 rtl/dense_bias_relu.sv | 107 ++++++++++
 tb/tb_dense_bias_relu.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// Shared fixed-point defaults and saturating arithmetic for the dense-layer datapath.
package dense_pkg;

  localparam int NUM_NEURONS_DEF = 128;
  localparam int ADDR_W_DEF      = 7;
  localparam int DATA_W_DEF      = 16;

  typedef logic signed [DATA_W_DEF-1:0] fx_t;

  localparam fx_t FX_MAX = 16'sh7fff;
  localparam fx_t FX_MIN = 16'sh8000;

  // Sign-extend both operands by one bit, add, and clamp into the fx_t range.
  function automatic fx_t sat_add(input fx_t a, input fx_t b);
    logic [DATA_W_DEF:0] sum;
    sum = {a[DATA_W_DEF-1], a} + {b[DATA_W_DEF-1], b};
    case (sum[DATA_W_DEF:DATA_W_DEF-1])
      2'b01:   sat_add = FX_MAX;
      2'b10:   sat_add = FX_MIN;
      default: sat_add = fx_t'(sum[DATA_W_DEF-1:0]);
    endcase
  endfunction

endpackage

// File: rtl/dense_sat_relu.sv
// Combinational bias add with saturation and optional ReLU clamp.
// Width-generic so later layers with other precisions can reuse it.
module dense_sat_relu
  import dense_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RELU   = 1
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W:0]   sum_s;
  logic [DATA_W-1:0] sat_s;

  // Top two sum bits disagreeing means the true result left the DATA_W range.
  always_comb begin
    sum_s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    case (sum_s[DATA_W:DATA_W-1])
      2'b01:   sat_s = SAT_MAX;
      2'b10:   sat_s = SAT_MIN;
      default: sat_s = sum_s[DATA_W-1:0];
    endcase
    if ((RELU != 0) && sat_s[DATA_W-1]) begin
      y = {DATA_W{1'b0}};
    end else begin
      y = sat_s;
    end
  end

endmodule

// File: rtl/dense_bias_relu.sv
// Dense-layer output stage: fetches each neuron's bias from the external ROM in step
// with the incoming dot products, adds it with saturation/ReLU, and registers the result.
module dense_bias_relu
  import dense_pkg::*;
#(
  parameter int NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int RELU        = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              vec_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1'b1);

  logic [ADDR_W-1:0] idx_r;
  logic [ADDR_W-1:0] idx_next_s;
  logic              prime_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_last_r;
  logic              in_ready_s;
  logic              accept_s;
  logic              at_last_s;
  logic [DATA_W-1:0] result_s;

  dense_sat_relu #(
    .DATA_W (DATA_W),
    .RELU   (RELU)
  ) u_sat_relu (
    .a (in_data),
    .b (rom_data),
    .y (result_s)
  );

  // Handshake and next-neuron index; rom_addr looks one neuron ahead so the
  // ROM's registered output lines up with the next accepted input.
  always_comb begin
    in_ready_s = prime_r & (~out_valid_r | out_ready);
    accept_s   = in_valid & in_ready_s;
    at_last_s  = (idx_r == LAST_IDX);
    if (accept_s) begin
      if (at_last_s) begin
        idx_next_s = {ADDR_W{1'b0}};
      end else begin
        idx_next_s = idx_r + IDX_ONE;
      end
    end else begin
      idx_next_s = idx_r;
    end
  end

  // rom_data is garbage until the ROM has seen one edge with a valid address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prime_r <= 1'b0;
    end else begin
      prime_r <= 1'b1;
    end
  end

  // Neuron counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_r <= {ADDR_W{1'b0}};
    end else begin
      idx_r <= idx_next_s;
    end
  end

  // Single output register; a drain and a new accept in the same cycle just reload it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      out_last_r  <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= result_s;
      out_last_r  <= at_last_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign rom_addr  = idx_next_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign vec_done  = out_valid_r & out_ready & out_last_r;

endmodule

// File: tb/tb_dense_bias_relu.sv
// Directed bench: two instances (RELU=1 and RELU=0) share stimulus, each with its own ROM model.
module tb_dense_bias_relu;

  localparam int N  = 128;
  localparam int AW = 7;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          in_ready_a, out_valid_a, out_last_a, vec_done_a;
  logic [AW-1:0] rom_addr_a;
  logic [DW-1:0] rom_data_a, out_data_a;
  logic          in_ready_b, out_valid_b, out_last_b, vec_done_b;
  logic [AW-1:0] rom_addr_b;
  logic [DW-1:0] rom_data_b, out_data_b;

  logic [DW-1:0] bias_mem [0:N-1];

  int n_cmp = 0;
  int n_bad = 0;
  int nidx  = 0;
  int stall_len;

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] exp_relu;
    logic [DW-1:0] exp_lin;
  } vec_t;
  vec_t tbl [0:5];

  dense_bias_relu #(.NUM_NEURONS(N), .ADDR_W(AW), .DATA_W(DW), .RELU(1)) u_relu (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_last(out_last_a), .vec_done(vec_done_a)
  );

  dense_bias_relu #(.NUM_NEURONS(N), .ADDR_W(AW), .DATA_W(DW), .RELU(0)) u_lin (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_last(out_last_b), .vec_done(vec_done_b)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    rom_data_a <= bias_mem[rom_addr_a];
    rom_data_b <= bias_mem[rom_addr_b];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " out_valid"}, out_valid_a, 1'b0);
    check({tag, " out_data"},  out_data_a,  16'h0000);
    check({tag, " out_last"},  out_last_a,  1'b0);
    check({tag, " in_ready"},  in_ready_a,  1'b0);
    check({tag, " rom_addr"},  rom_addr_a,  7'd0);
    check({tag, " vec_done"},  vec_done_a,  1'b0);
    check({tag, " lin out_valid"}, out_valid_b, 1'b0);
    check({tag, " lin out_data"},  out_data_b,  16'h0000);
  endtask

  // One accepted input per call; called #1 after a rising edge with out_ready=1.
  task automatic send(input logic [DW-1:0] din, input logic [DW-1:0] er, input logic [DW-1:0] el);
    logic          exp_last;
    logic [AW-1:0] exp_addr;
    exp_last = (nidx == N - 1);
    exp_addr = exp_last ? 7'd0 : 7'(nidx + 1);
    in_valid = 1'b1;
    in_data  = din;
    #1;
    check($sformatf("in_ready n%0d", nidx), in_ready_a, 1'b1);
    check($sformatf("rom_addr n%0d", nidx), rom_addr_a, exp_addr);
    @(posedge clock);
    #1;
    check($sformatf("out_valid n%0d", nidx), out_valid_a, 1'b1);
    check($sformatf("relu out_data n%0d", nidx), out_data_a, er);
    check($sformatf("lin out_data n%0d", nidx), out_data_b, el);
    check($sformatf("out_last n%0d", nidx), out_last_a, exp_last);
    check($sformatf("vec_done n%0d", nidx), vec_done_a, exp_last);
    check($sformatf("lin vec_done n%0d", nidx), vec_done_b, exp_last);
    nidx = exp_last ? 0 : nidx + 1;
  endtask

  // Streaming pattern: bias[k]=k for k>=2, in=2k so result=3k.
  task automatic send_k(input int k);
    if (k == 0) begin
      send(16'h0020, 16'h0130, 16'h0130);
    end else if (k == 1) begin
      send(16'h0300, 16'h0090, 16'h0090);
    end else begin
      send(16'(2 * k), 16'(3 * k), 16'(3 * k));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) bias_mem[i] = 16'(i);
    bias_mem[0] = 16'h0110;
    bias_mem[1] = 16'hfd90;

    tbl[0] = '{16'h0100, 16'h0210, 16'h0210};
    tbl[1] = '{16'h0200, 16'h0000, 16'hff90};
    tbl[2] = '{16'h0005, 16'h0007, 16'h0007};
    tbl[3] = '{16'hfff0, 16'h0000, 16'hfff3};
    tbl[4] = '{16'h7ffe, 16'h7fff, 16'h7fff};
    tbl[5] = '{16'h8000, 16'h0000, 16'h8005};

    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0100;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_reset("reset");
    #2 reset_n = 1'b1;
    #1;
    check("prime in_ready", in_ready_a, 1'b0);
    check("prime out_valid", out_valid_a, 1'b0);
    @(posedge clock);
    #1;
    check("post-prime out_valid", out_valid_a, 1'b0);

    // Vector 1: table head, then the streaming pattern.
    for (int i = 0; i < 6; i++) send(tbl[i].din, tbl[i].exp_relu, tbl[i].exp_lin);
    for (int k = 6; k < N; k++) send_k(k);

    // Vector 2 back-to-back: saturation at both rails, then streaming.
    send(16'h7ff0, 16'h7fff, 16'h7fff);
    send(16'h8000, 16'h0000, 16'h8000);
    for (int k = 2; k < N; k++) send_k(k);

    // Vector 3: stall at neuron 40.
    for (int k = 0; k < 40; k++) send_k(k);
    in_valid  = 1'b1;
    in_data   = 16'(80);
    out_ready = 1'b0;
    stall_len = int'($urandom_range(5, 2));
    #1;
    for (int s = 0; s < stall_len; s++) begin
      check($sformatf("stall%0d in_ready", s), in_ready_a, 1'b0);
      check($sformatf("stall%0d out_valid", s), out_valid_a, 1'b1);
      check($sformatf("stall%0d out_data", s), out_data_a, 16'(117));
      check($sformatf("stall%0d rom_addr", s), rom_addr_a, 7'd40);
      check($sformatf("stall%0d vec_done", s), vec_done_a, 1'b0);
      @(posedge clock);
      #1;
    end
    out_ready = 1'b1;
    for (int k = 40; k < 60; k++) send_k(k);

    // Stall at neuron 60, then reset mid-stall.
    in_valid  = 1'b1;
    in_data   = 16'(120);
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("stall60 out_data", out_data_a, 16'(177));
    check("stall60 rom_addr", rom_addr_a, 7'd60);
    reset_n = 1'b0;
    #1;
    check_reset("mid-stall reset");
    @(posedge clock);
    #3;
    reset_n   = 1'b1;
    nidx      = 0;
    out_ready = 1'b1;
    in_data   = 16'h0020;
    #1;
    check("re-prime in_ready", in_ready_a, 1'b0);
    @(posedge clock);
    #1;
    send_k(0);
    send_k(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
